// File: rtl/hub75_line_shifter.sv
// hub75_line_shifter: reads one line of pixel words from the line buffer,
// picks one bit-plane per colour channel and shifts the columns out on the
// HUB75 data/clock pins (one column every two cycles).
module hub75_line_shifter #(
  parameter int N_BANKS     = 2,
  parameter int N_CHANS     = 3,
  parameter int N_PLANES    = 8,
  parameter int N_COLS      = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int PLANE_WIDTH = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PLANE_WIDTH-1:0]              ctrl_plane,
  input  logic                                ctrl_go,
  output logic                                ctrl_rdy,
  output logic                                ctrl_done,
  output logic [ADDR_WIDTH-1:0]               buf_rd_addr,
  output logic                                buf_rd_ena,
  input  logic [N_BANKS*N_CHANS*N_PLANES-1:0] buf_rd_data,
  output logic [N_BANKS*N_CHANS-1:0]          phy_data,
  output logic                                phy_clk
);

  localparam int NL = N_BANKS * N_CHANS;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [PLANE_WIDTH-1:0]  plane_q, plane_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   col_nxt;
  logic                    ena_q, ena_d;
  logic                    phase_q, phase_d;
  logic                    done_q, done_d;
  // vld_pipe[0]: read data valid this cycle; vld_pipe[1]: column on pins, raise clock next
  logic [1:0]              vld_pipe_q, vld_pipe_d;
  logic [NL-1:0]           phy_data_q, phy_data_d;
  logic                    phy_clk_q, phy_clk_d;
  logic [NL-1:0]           plane_bits;

  assign col_nxt = addr_q + ADDR_WIDTH'(1);

  // Control FSM: accept, one read every other cycle, two-cycle drain, done.
  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    addr_d  = addr_q;
    ena_d   = 1'b0;
    phase_d = phase_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_go) begin
          state_d = SHIFT;
          plane_d = ctrl_plane;
          addr_d  = '0;
          ena_d   = 1'b1;
          phase_d = 1'b0;
        end
      end
      SHIFT: begin
        // ena_q marks the read cycle; the following cycle decides what comes next
        if (!ena_q) begin
          if (col_nxt == '0) begin
            state_d = FLUSH;
            phase_d = 1'b0;
          end else begin
            addr_d = col_nxt;
            ena_d  = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-plane extraction; an out-of-range plane selects nothing, giving zeros.
  always_comb begin
    plane_bits = '0;
    for (int i = 0; i < NL; i++) begin
      for (int p = 0; p < N_PLANES; p++) begin
        if (plane_q == PLANE_WIDTH'(p)) plane_bits[i] = buf_rd_data[i*N_PLANES + p];
      end
    end
  end

  // Output pipeline: load data with clock low, raise clock the next cycle.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], ena_q};
    phy_clk_d  = vld_pipe_q[1];
    phy_data_d = phy_data_q;
    if (vld_pipe_q[0])  phy_data_d = plane_bits;
    else if (done_d)    phy_data_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      plane_q    <= '0;
      addr_q     <= '0;
      ena_q      <= 1'b0;
      phase_q    <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      phy_data_q <= '0;
      phy_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      plane_q    <= plane_d;
      addr_q     <= addr_d;
      ena_q      <= ena_d;
      phase_q    <= phase_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      phy_data_q <= phy_data_d;
      phy_clk_q  <= phy_clk_d;
    end
  end

  assign ctrl_rdy    = (state_q == IDLE);
  assign ctrl_done   = done_q;
  assign buf_rd_addr = addr_q;
  assign buf_rd_ena  = ena_q;
  assign phy_data    = phy_data_q;
  assign phy_clk     = phy_clk_q;

endmodule
